// File: rtl/darkriscv_macu.sv
// darkriscv_macu: 2-stage SIMD multiply-accumulate unit for the MAC opcode.
// Optional feature macro: MACU_SAT_EN (clamp accumulators on overflow, else wrap).
// Ports: CLK, RES (sync, active-high), HLT (freeze), REQ/ACK (issue handshake),
//   OP (0 MAC, 1 MUL, 2 CLR, 3 RD), SGN, AIDX, RS1/RS2 (operands),
//   RDY (result pulse), RESULT, OVF (sticky per-acc overflow), BUSY.
module darkriscv_macu #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int ACC_W = 32,
  parameter int NACC  = 4,
  localparam int AW   = (NACC > 1) ? $clog2(NACC) : 1
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            HLT,
  input  logic            REQ,
  output logic            ACK,
  input  logic [1:0]      OP,
  input  logic            SGN,
  input  logic [AW-1:0]   AIDX,
  input  logic [31:0]     RS1,
  input  logic [31:0]     RS2,
  output logic            RDY,
  output logic [31:0]     RESULT,
  output logic [NACC-1:0] OVF,
  output logic            BUSY
);

  typedef enum logic [1:0] {
    OP_MAC = 2'd0,
    OP_MUL = 2'd1,
    OP_CLR = 2'd2,
    OP_RD  = 2'd3
  } op_e;

  localparam int PW = 2 * WIDTH;
  // Wide enough for any lane-sum plus any accumulator, so the
  // overflow test is exact for every legal parameter set.
  localparam int BW = PW + ACC_W + LANES;

  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic             v1_q, v2_q;
  op_e              op1_q;
  logic             sgn1_q;
  logic [AW-1:0]    idx1_q;
  logic [PW-1:0]    prod_q [LANES];
  logic [PW-1:0]    prod_d [LANES];
  logic [ACC_W-1:0] acc_q  [NACC];
  logic [NACC-1:0]  ovf_q;
  logic [31:0]      result_q;

  logic             accept;
  logic [BW-1:0]    sum_d, acc_x, new_d;
  logic [ACC_W-1:0] acc_cur, wr_d;
  logic [31:0]      res_d;
  logic             fits, ovf_d;

  assign ACK    = !RES && !HLT;
  assign accept = REQ && ACK;

  // Operands are pre-extended per SGN, so one unsigned
  // multiplier yields the correct low 2*WIDTH bits.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] a, b;
    assign a = {{WIDTH{SGN & RS1[i*WIDTH+WIDTH-1]}},
                RS1[i*WIDTH +: WIDTH]};
    assign b = {{WIDTH{SGN & RS2[i*WIDTH+WIDTH-1]}},
                RS2[i*WIDTH +: WIDTH]};
    assign prod_d[i] = a * b;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d +
        {{(BW-PW){sgn1_q & prod_q[i][PW-1]}}, prod_q[i]};
    end
    acc_cur = acc_q[idx1_q];
    acc_x   = {{(BW-ACC_W){sgn1_q & acc_cur[ACC_W-1]}},
               acc_cur};
    new_d   = sum_d + ((op1_q == OP_MAC) ? acc_x : '0);
    if (sgn1_q)
      fits = (&new_d[BW-1:ACC_W-1]) |
             (~|new_d[BW-1:ACC_W-1]);
    else
      fits = ~|new_d[BW-1:ACC_W];
    ovf_d = 1'b0;
    wr_d  = new_d[ACC_W-1:0];
    unique case (1'b1)
      (op1_q == OP_MAC),
      (op1_q == OP_MUL): begin
        ovf_d = !fits;
`ifdef MACU_SAT_EN
        if (!fits) begin
          if (new_d[BW-1])
            wr_d = sgn1_q ? SMIN : '0;
          else
            wr_d = sgn1_q ? SMAX : '1;
        end
`endif
      end
      (op1_q == OP_CLR): wr_d = '0;
      (op1_q == OP_RD):  wr_d = acc_cur;
    endcase
    if (sgn1_q)
      res_d = 32'($signed(wr_d));
    else
      res_d = 32'(wr_d);
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      op1_q    <= OP_MAC;
      sgn1_q   <= 1'b0;
      idx1_q   <= '0;
      ovf_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      for (int i = 0; i < NACC; i++)  acc_q[i]  <= '0;
    end else if (!HLT) begin
      v1_q <= accept;
      v2_q <= v1_q;
      if (accept) begin
        op1_q  <= op_e'(OP);
        sgn1_q <= SGN;
        idx1_q <= AIDX;
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
      // Stage 2 is a single-edge read-modify-write, so a
      // following op on the same index sees this write.
      if (v1_q) begin
        acc_q[idx1_q] <= wr_d;
        result_q      <= res_d;
        if (op1_q == OP_CLR)
          ovf_q[idx1_q] <= 1'b0;
        else if (ovf_d)
          ovf_q[idx1_q] <= 1'b1;
      end
    end
  end

  // A completed op waits in v2_q while halted.
  assign RDY    = v2_q && !HLT;
  assign RESULT = result_q;
  assign OVF    = ovf_q;
  assign BUSY   = v1_q | v2_q;

endmodule

// File: doc/darkriscv_macu.md
# darkriscv_macu

Parametrised SIMD multiply-accumulate coprocessor for the darkriscv core, executing the custom `MAC` opcode (7'b11111_11) that the current core only decodes. It takes the two source-register values, splits them into `LANES` sub-words, forms a lane-wise dot product and adds it into one of `NACC` internal accumulators. It sits beside the core's RM-group datapath. Issue is a REQ/ACK handshake, and results return two clock edges later with an RDY pulse.

## Interface
- `LANES`, default 4: sub-words per 32-bit operand; `LANES*WIDTH` must equal 32.
- `WIDTH`, default 8: lane width in bits.
- `ACC_W`, default 32: accumulator width, legal 16..32.
- `NACC`, default 4: number of accumulators, power of 2, ≥2.
- `CLK` in 1: clock.
- `RES` in 1: reset, synchronous, active-high.
- `HLT` in 1: core halt; freezes the whole pipeline.
- `REQ` in 1: issue request.
- `ACK` out 1: ready to accept; equals `!RES && !HLT`.
- `OP` in 2: 0=MAC (acc+=dot), 1=MUL (acc=dot), 2=CLR (acc=0), 3=RD (read acc).
- `SGN` in 1: signed lanes and signed result extension.
- `AIDX` in log2(NACC): accumulator select.
- `RS1`, `RS2` in 32: operands.
- `RDY` out 1: result-valid pulse.
- `RESULT` out 32: result.
- `OVF` out NACC: per-accumulator sticky overflow flags.
- `BUSY` out 1: any pipeline stage valid.

## Operation
- An op is accepted on an edge where `REQ && ACK`.
- Stage 1 registers `OP`, `SGN` and `AIDX`. It also registers the `LANES` products, lane i = `RS1[i*WIDTH +: WIDTH] * RS2[i*WIDTH +: WIDTH]`.
  - Product width is 2*WIDTH.
  - Products are signed when `SGN`=1, unsigned otherwise.
- Stage 2 operation:
  - Sums all products, extended per `SGN` to ACC_W+LANES bits.
  - Computes `new = (OP==MAC ? acc[AIDX] : 0) + sum`.
  - Writes `new` to acc[AIDX] and the extended result to `RESULT`.
- CLR writes 0, returns 0 and clears `OVF[AIDX]`.
- RD leaves acc unchanged and returns it.
- Overflow means `new` is outside the ACC_W range: signed range when `SGN`=1, [0, 2^ACC_W-1] when `SGN`=0. On overflow `OVF[AIDX]` is set and stays set until CLR or reset. The stored value depends on configuration (see below).
- `RESULT` = acc value sign-extended (`SGN`=1) or zero-extended (`SGN`=0) to 32 bits.
- There is no accumulator hazard. An op's stage 2 reads the acc after the preceding op's stage-2 write, so back-to-back ops on one index chain correctly.
- Ops with the same `AIDX` complete in issue order.
- Reset: all accumulators 0, both stage-valid bits 0. Output reset values: `RDY`=0, `RESULT`=0, `OVF`=0, `BUSY`=0, `ACK`=0.

## Timing
- Accept at edge T0. Stage 1 is valid after T0. The stage-2 write and `RDY`=1 with `RESULT` valid occur after T0+1, for the cycle between T0+1 and T0+2.
- Latency is 2 edges. Throughput is one op per cycle, so `RDY` can be high on consecutive cycles.
- `RDY` is a single-cycle pulse per op. `RESULT` holds its value until the next `RDY`.
- `HLT`=1:
  - No accept.
  - All stage, accumulator and `OVF` registers hold.
  - `RDY` is forced 0.
  - A stage-2 op pending at `HLT` assertion is presented (`RDY`=1) on the first cycle after `HLT` drops, with its value unchanged.
- `RES` during operation:
  - In-flight ops are discarded.
  - No `RDY` is produced for them.
  - Accumulators and `OVF` are 0 on the next cycle.
- `RES` and `REQ` in the same cycle: the request is ignored.
- `BUSY` = stage1_valid | stage2_valid.

## Configuration
- `MACU_SAT_EN` defined: on overflow the acc is clamped.
  - Signed clamp targets: 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Unsigned clamp targets: 2^ACC_W-1 or 0.
- `MACU_SAT_EN` undefined: the acc wraps modulo 2^ACC_W. `OVF` is still set in both cases.

## Test plan
All scenarios use default parameters unless noted.
- Reset: hold `RES` 2 cycles, then RD acc0 → `RDY`=1, `RESULT`=0, `OVF`=0, `BUSY`=0 when idle.
- Chained MAC: CLR acc0, then MAC `SGN`=1 RS1=0x01020304 RS2=0x01010101 twice back-to-back → `RDY` on two consecutive cycles, `RESULT`=10 then 20.
- Signedness: MUL acc1 RS1=0xFFFFFFFF RS2=0x02020202.
  - `SGN`=1 → 0xFFFFFFF8.
  - `SGN`=0 → 0x000007F8.
- Overflow, `ACC_W`=16: MAC `SGN`=1 RS1=RS2=0x7F7F7F7F into cleared acc2 (dot = 64516).
  - With `MACU_SAT_EN` → `RESULT`=0x00007FFF.
  - Without → `RESULT`=0xFFFFFC04.
  - Both cases → `OVF[2]`=1. A subsequent CLR clears `OVF[2]`.
- Halt: issue MAC at T0, hold `HLT` high for 3 cycles starting the cycle after T0 → `RDY` appears 3 cycles later than nominal with the correct value, and `ACK`=0 throughout the halt.
- Reset mid-flight: MAC acc0 at T0 with `RES` asserted the next cycle → no `RDY`, and a later RD of acc0 returns 0.
